// File: rtl/ps2_key_ctrl.sv
// rtl/ps2_key_ctrl.sv - PS/2 scan-code sequencer: prefix/Pause decoder feeding a fall-through event FIFO.
// Optional inter-byte timeout is built when PS2_KEY_TIMEOUT_EN is defined.
module ps2_key_ctrl #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        rx_done_tick,
  input  logic [7:0]                  rx_data,
  output logic                        rx_en,
  output logic                        evt_valid,
  input  logic                        evt_ready,
  output logic [7:0]                  evt_code,
  output logic                        evt_ext,
  output logic                        evt_brk,
  output logic [$clog2(FIFO_DEPTH):0] evt_count,
  output logic                        ovf,
  input  logic                        ovf_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_PREFIX, S_PAUSE} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_ext, r_brk, w_ext_nxt, w_brk_nxt;
  logic [2:0]  r_skip, w_skip_nxt;
  logic        w_push;
  logic [9:0]  w_push_evt;
  logic        w_status;
  logic        w_timeout;

  logic [9:0]  r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0] r_count;
  logic        r_ovf, r_rx_en;
  logic        w_full, w_pop, w_wr, w_drop;
  logic [9:0]  w_head;

  assign w_status = (rx_data == 8'h00) || (rx_data == 8'hAA) || (rx_data == 8'hEE) ||
                    (rx_data == 8'hFA) || (rx_data == 8'hFE) || (rx_data == 8'hFF);

`ifdef PS2_KEY_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] r_gap;

  always_ff @(posedge clk) begin
    if (reset || rx_done_tick || r_state == S_IDLE) r_gap <= '0;
    else                                            r_gap <= r_gap + 1'b1;
  end

  assign w_timeout = !rx_done_tick && (r_state != S_IDLE) && (r_gap == TW'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ext   <= 1'b0;
      r_brk   <= 1'b0;
      r_skip  <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_ext   <= w_ext_nxt;
      r_brk   <= w_brk_nxt;
      r_skip  <= w_skip_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ext_nxt   = r_ext;
    w_brk_nxt   = r_brk;
    w_skip_nxt  = r_skip;
    w_push      = 1'b0;
    w_push_evt  = {rx_data, 2'b00};
    if (w_timeout) begin
      w_state_nxt = S_IDLE;
      w_ext_nxt   = 1'b0;
      w_brk_nxt   = 1'b0;
    end else if (rx_done_tick) begin
      case (r_state)
        S_IDLE: begin
          if (rx_data == 8'hE0) begin
            w_ext_nxt   = 1'b1;
            w_state_nxt = S_PREFIX;
          end else if (rx_data == 8'hF0) begin
            w_brk_nxt   = 1'b1;
            w_state_nxt = S_PREFIX;
          end else if (rx_data == 8'hE1) begin
            w_skip_nxt  = 3'd7;
            w_state_nxt = S_PAUSE;
          end else if (!w_status) begin
            w_push = 1'b1;
          end
        end
        S_PREFIX: begin
          if (rx_data == 8'hE0) begin
            w_ext_nxt = 1'b1;
          end else if (rx_data == 8'hF0) begin
            w_brk_nxt = 1'b1;
          end else begin
            // Status or a stray E1 mid-prefix abandons the sequence silently.
            w_push      = !(w_status || rx_data == 8'hE1);
            w_push_evt  = {rx_data, r_ext, r_brk};
            w_ext_nxt   = 1'b0;
            w_brk_nxt   = 1'b0;
            w_state_nxt = S_IDLE;
          end
        end
        S_PAUSE: begin
          w_skip_nxt = r_skip - 3'd1;
          if (r_skip == 3'd1) begin
            w_push      = 1'b1;
            w_push_evt  = {8'hE1, 2'b10};
            w_state_nxt = S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign w_full = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_pop  = evt_valid && evt_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
  assign w_wr   = w_push && (!w_full || w_pop);
  assign w_drop = w_push && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= w_push_evt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_rx_en <= 1'b0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_ovf   <= w_drop || (r_ovf && !ovf_clr);
      r_rx_en <= (r_count <= (AW+1)'(FIFO_DEPTH - 2));
    end
  end

  assign evt_valid = (r_count != '0);
  assign w_head    = evt_valid ? r_mem[r_rptr] : 10'd0;
  assign evt_code  = w_head[9:2];
  assign evt_ext   = w_head[1];
  assign evt_brk   = w_head[0];
  assign evt_count = r_count;
  assign ovf       = r_ovf;
  assign rx_en     = r_rx_en;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// tb/tb_ps2_key_ctrl.sv - randomized bench for ps2_key_ctrl against a sequence-level reference model.
module tb_ps2_key_ctrl;

  localparam int DEPTH = 8;
  localparam int TO    = 50;
`ifdef PS2_KEY_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_done_tick = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_en;
  logic       evt_valid;
  logic       evt_ready = 1'b0;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_brk;
  logic [3:0] evt_count;
  logic       ovf;
  logic       ovf_clr = 1'b0;

  ps2_key_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
    .rx_en(rx_en), .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
    .evt_ext(evt_ext), .evt_brk(evt_brk), .evt_count(evt_count), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: pending prefix bytes of the current sequence and the queued events {code,ext,brk}.
  logic [9:0] m_q[$];
  logic [7:0] m_seq[$];
  bit         m_ovf   = 1'b0;
  bit         m_rx_en = 1'b0;
  int         m_cyc   = 0;
  int         m_last  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit is_status(input logic [7:0] b);
    return b == 8'h00 || b == 8'hAA || b == 8'hEE || b == 8'hFA || b == 8'hFE || b == 8'hFF;
  endfunction

  function automatic bit seq_has(input logic [7:0] b);
    foreach (m_seq[i]) if (m_seq[i] == b) return 1'b1;
    return 1'b0;
  endfunction

  task automatic compare_all();
    logic [9:0] head;
    head = (m_q.size() != 0) ? m_q[0] : 10'd0;
    check("valid", 32'(evt_valid), 32'(m_q.size() != 0));
    check("count", 32'(evt_count), 32'(m_q.size()));
    check("head",  32'({evt_code, evt_ext, evt_brk}), 32'(head));
    check("rx_en", 32'(rx_en), 32'(m_rx_en));
    check("ovf",   32'(ovf), 32'(m_ovf));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rx_done_tick = 1'b0;
    @(posedge clk);
    #1;
    m_q.delete();
    m_seq.delete();
    m_ovf   = 1'b0;
    m_rx_en = 1'b0;
    m_cyc++;
    compare_all();
    reset = 1'b0;
  endtask

  task automatic step(input bit tick, input logic [7:0] data, input bit rdy, input bit clr);
    bit         push;
    bit         pop;
    logic [9:0] ev;
    rx_done_tick = tick;
    rx_data      = data;
    evt_ready    = rdy;
    ovf_clr      = clr;
    @(posedge clk);
    push = 1'b0;
    ev   = 10'd0;
    if (tick) begin
      m_last = m_cyc;
      if (m_seq.size() == 0) begin
        if (data == 8'hE0 || data == 8'hF0 || data == 8'hE1) m_seq.push_back(data);
        else if (!is_status(data)) begin push = 1'b1; ev = {data, 2'b00}; end
      end else if (m_seq[0] == 8'hE1) begin
        m_seq.push_back(data);
        if (m_seq.size() == 8) begin push = 1'b1; ev = {8'hE1, 2'b10}; m_seq.delete(); end
      end else if (data == 8'hE0 || data == 8'hF0) begin
        m_seq.push_back(data);
      end else begin
        if (!(is_status(data) || data == 8'hE1)) begin
          push = 1'b1;
          ev   = {data, seq_has(8'hE0), seq_has(8'hF0)};
        end
        m_seq.delete();
      end
    end else if (TO_EN && m_seq.size() != 0 && (m_cyc - m_last) >= TO) begin
      m_seq.delete();
    end
    m_rx_en = (m_q.size() <= DEPTH - 2);
    pop = rdy && (m_q.size() != 0);
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (m_q.size() < DEPTH) m_q.push_back(ev);
      else m_ovf = 1'b1;
    end else if (clr) begin
      m_ovf = 1'b0;
    end
    m_cyc++;
    #1;
    compare_all();
  endtask

  task automatic send(input logic [7:0] b, input bit rdy);
    step(1'b1, b, rdy, 1'b0);
    repeat ($urandom_range(0, 2)) step(1'b0, 8'h00, rdy, 1'b0);
  endtask

  task automatic drain();
    repeat (DEPTH + 2) step(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  function automatic logic [7:0] rand_byte();
    logic [7:0] st [6];
    st = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
    case ($urandom_range(0, 9))
      0:       return 8'hE0;
      1:       return 8'hF0;
      2:       return ($urandom_range(0, 3) == 0) ? 8'hE1 : 8'hF0;
      3:       return st[$urandom_range(0, 5)];
      default: return 8'($urandom_range(1, 8'hDF));
    endcase
  endfunction

  initial begin
    logic [7:0] pause_seq [8];
    pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

    do_reset();
    repeat (2) step(1'b0, 8'h00, 1'b0, 1'b0);

    send(8'h1C, 1'b0);
    send(8'hF0, 1'b0); send(8'h1C, 1'b0);
    send(8'hE0, 1'b0); send(8'hF0, 1'b0); send(8'h75, 1'b0);
    send(8'hE0, 1'b0); send(8'hFA, 1'b0); send(8'h1C, 1'b0);
    drain();
    foreach (pause_seq[i]) send(pause_seq[i], 1'b0);
    check("pause_evt", 32'({evt_code, evt_ext, evt_brk}), 32'({8'hE1, 2'b10}));
    send(8'hAA, 1'b0);
    check("status_drop", 32'(evt_count), 32'd1);
    drain();

    for (int i = 0; i < 9; i++) send(8'(8'h15 + i), 1'b0);
    check("ovf_set", 32'(ovf), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("ovf_clr", 32'(ovf), 32'd0);
    step(1'b1, 8'h1C, 1'b1, 1'b0);
    check("full_pushpop", 32'(evt_count), 32'd8);
    drain();

    do_reset();
    step(1'b1, 8'hE0, 1'b0, 1'b0);
    repeat (TO + 10) step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'h1C, 1'b0, 1'b0);
    check("timeout_evt", 32'({evt_code, evt_ext, evt_brk}), TO_EN ? 32'({8'h1C, 2'b00}) : 32'({8'h1C, 2'b10}));

    do_reset();
    send(8'h16, 1'b0); send(8'h1E, 1'b0); send(8'h26, 1'b0);
    send(8'hF0, 1'b0);
    do_reset();
    check("rst_count", 32'(evt_count), 32'd0);
    step(1'b1, 8'h1C, 1'b0, 1'b0);
    check("rst_evt", 32'({evt_code, evt_ext, evt_brk}), 32'({8'h1C, 2'b00}));

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      else step($urandom_range(0, 2) == 0, rand_byte(), $urandom_range(0, 2) == 0,
                $urandom_range(0, 15) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_key_ctrl.md
# ps2_key_ctrl

Sequences the PS/2 keyboard receive path. It gates the receiver's `rx_en`, decodes the incoming byte stream (prefixes `E0`, `F0` and the `E1` Pause sequence) into whole key events, and buffers them in a FIFO for the CPU/system side. It sits between the PS/2 receiver (`rx_done_tick`, `rx_data`) and the keyboard register interface, and provides flow control so a slow consumer causes receive back-pressure.

## Interface
Parameters:
- `FIFO_DEPTH`, default 8: event FIFO entries; power of two, minimum 4.
- `TIMEOUT_CYCLES`, default 1_000_000: maximum gap in clk cycles allowed between bytes of one multi-byte sequence.

Ports (reset `reset`, synchronous, active-high; clock `clk`):
- `clk`, in, 1: system clock.
- `reset`, in, 1: synchronous, active-high.
- `rx_done_tick`, in, 1: one-cycle strobe from the receiver; a byte is valid on `rx_data`.
- `rx_data`, in, 8: received byte, sampled when `rx_done_tick`=1.
- `rx_en`, out, 1: receive enable to the receiver.
- `evt_valid`, out, 1: FIFO non-empty.
- `evt_ready`, in, 1: consumer pop. Pop occurs when `evt_valid & evt_ready`.
- `evt_code`, out, 8: head event key code.
- `evt_ext`, out, 1: head event is extended (E0 or E1).
- `evt_brk`, out, 1: head event is a release (break).
- `evt_count`, out, $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- `ovf`, out, 1: sticky flag; an event was dropped because the FIFO was full.
- `ovf_clr`, in, 1: clears `ovf`. If a new drop occurs in the same cycle, the set wins.

## Operation
- Reset values: `rx_en`=0 for the reset cycle and 1 afterwards (FIFO empty). `evt_valid`=0, `evt_code`=0, `evt_ext`=0, `evt_brk`=0, `evt_count`=0, `ovf`=0. FSM is in IDLE and the flags are cleared.
- FSM states:
  - **IDLE**
    - `E0`: set ext, go to PREFIX.
    - `F0`: set brk, go to PREFIX.
    - `E1`: load skip counter with 7, go to PAUSE.
    - Status bytes `00, AA, EE, FA, FE, FF`: dropped.
    - Any other byte: push {code, ext=0, brk=0}.
  - **PREFIX**
    - `E0`: set ext, stay.
    - `F0`: set brk, stay.
    - Status byte or `E1`: abort to IDLE, flags cleared, nothing pushed.
    - Any other byte: push {code, ext, brk}, clear flags, go to IDLE.
  - **PAUSE**
    - Each byte decrements the skip counter; byte contents are ignored.
    - When the counter reaches 0 on a byte: push {E1, ext=1, brk=0}, go to IDLE.
- FSM advances only on `rx_done_tick`.
- FIFO behaviour:
  - First-word fall-through; the head is driven from registered storage.
  - A push when full drops the event and sets `ovf`. State still returns to IDLE.
  - Simultaneous push and pop while full: both are accepted and occupancy is unchanged.
  - Pop while empty is ignored.
  - Read/write pointers wrap modulo FIFO_DEPTH.
- `rx_en` = (`evt_count` <= FIFO_DEPTH-2), registered.
  - Deassertion only stops new frames. A frame already in flight still completes and is processed; it may overflow.

## Timing
- `rx_done_tick` in cycle N that completes an event: `evt_valid`=1 and the head fields are updated in cycle N+1 (FIFO previously empty). `evt_count` increments in N+1.
- Pop in cycle N: the next head (or `evt_valid`=0) appears in N+1.
- `rx_en` reflects the occupancy of cycle N in cycle N+1.
- `ovf` sets in the cycle after the dropped push.
- Reset mid-sequence (PREFIX/PAUSE) returns to IDLE and empties the FIFO. A following non-prefix byte yields ext=0, brk=0.

## Configuration
- `PS2_KEY_TIMEOUT_EN` defined:
  - A gap counter clears on every `rx_done_tick`.
  - In PREFIX or PAUSE, when the counter reaches TIMEOUT_CYCLES-1 with no byte, the FSM returns to IDLE, clears the flags, and pushes nothing.
  - In IDLE the counter is held at 0.
- Undefined:
  - No counter logic is built and `TIMEOUT_CYCLES` is ignored.
  - PREFIX/PAUSE persist until the next byte.

## Test plan
- Bytes `1C` then `F0 1C` -> events {1C,0,0}, {1C,0,1}. `evt_valid` rises 1 cycle after each final `rx_done_tick`.
- `E0 F0 75` -> single event {75,1,1}. `E0 FA 1C` -> abort, then {1C,0,0}.
- Pause `E1 14 77 E1 F0 14 F0 77` -> exactly one event {E1,1,0}. `AA` alone -> no event.
- FIFO_DEPTH=8, `evt_ready`=0, send 9 make codes:
  - `rx_en` falls the cycle after `evt_count`=7.
  - The 9th byte (forced in) is dropped and `ovf`=1.
  - Assert `ovf_clr` -> `ovf`=0.
  - Full + simultaneous push and pop -> `evt_count` stays 8.
- `E0`, then idle TIMEOUT_CYCLES+10 cycles, then `1C`: with `PS2_KEY_TIMEOUT_EN` -> {1C,0,0}; without -> {1C,1,0}.
- `reset` asserted after `F0` with 3 events queued -> `evt_count`=0, `evt_valid`=0. Next `1C` -> {1C,0,0}.
